// File: rtl/button_debouncer.sv
// Push-button front end: two-flop synchronizer, debounce FSM, press/release strobes.
// Optional auto-repeat of PressPulse while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_WIDTH       = 19,
  parameter int unsigned REPEAT_CYCLES   = 25000000,
  parameter int unsigned REPEAT_WIDTH    = 25
) (
  input  logic Clk,
  input  logic Rst,
  input  logic ButtonIn,
  output logic ButtonLevel,
  output logic PressPulse,
  output logic ReleasePulse
);

  typedef enum logic [1:0] {
    StReleased,
    StWaitPress,
    StPressed,
    StWaitRelease
  } stateT;

  localparam logic [CNT_WIDTH-1:0] CntLast = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Reject configurations where the counters cannot reach their terminal values.
  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_WIDTH)) begin : gBadDebounce
    $error("DEBOUNCE_CYCLES does not fit CNT_WIDTH");
  end
  if (REPEAT_CYCLES < 2 || 64'(REPEAT_CYCLES) > (64'd1 << REPEAT_WIDTH)) begin : gBadRepeat
    $error("REPEAT_CYCLES does not fit REPEAT_WIDTH");
  end

  logic                 sync1Q, sync2Q;
  stateT                stateQ, stateD;
  logic [CNT_WIDTH-1:0] cntQ, cntD;
  logic                 levelQ, levelD;
  logic                 pressQ, pressD;
  logic                 releaseQ, releaseD;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [REPEAT_WIDTH-1:0] RepLast = REPEAT_WIDTH'(REPEAT_CYCLES - 1);

  logic [REPEAT_WIDTH-1:0] rcntQ, rcntD;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rcntQ <= '0;
    end else begin
      rcntQ <= rcntD;
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync1Q   <= 1'b0;
      sync2Q   <= 1'b0;
      stateQ   <= StReleased;
      cntQ     <= '0;
      levelQ   <= 1'b0;
      pressQ   <= 1'b0;
      releaseQ <= 1'b0;
    end else begin
      sync1Q   <= ButtonIn;
      sync2Q   <= sync1Q;
      stateQ   <= stateD;
      cntQ     <= cntD;
      levelQ   <= levelD;
      pressQ   <= pressD;
      releaseQ <= releaseD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    levelD   = levelQ;
    pressD   = 1'b0;
    releaseD = 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
    // Cleared everywhere except while held in StPressed, so every entry restarts it.
    rcntD    = '0;
`endif

    unique case (stateQ)
      StReleased: begin
        if (sync2Q) begin
          stateD = StWaitPress;
          cntD   = '0;
        end
      end

      StWaitPress: begin
        if (!sync2Q) begin
          stateD = StReleased;
        end else if (cntQ == CntLast) begin
          stateD = StPressed;
          levelD = 1'b1;
          pressD = 1'b1;
        end else begin
          cntD = cntQ + CNT_WIDTH'(1);
        end
      end

      StPressed: begin
        if (!sync2Q) begin
          stateD = StWaitRelease;
          cntD   = '0;
        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
          if (rcntQ == RepLast) begin
            pressD = 1'b1;
          end else begin
            rcntD = rcntQ + REPEAT_WIDTH'(1);
          end
`endif
        end
      end

      StWaitRelease: begin
        if (sync2Q) begin
          stateD = StPressed;
        end else if (cntQ == CntLast) begin
          stateD   = StReleased;
          levelD   = 1'b0;
          releaseD = 1'b1;
        end else begin
          cntD = cntQ + CNT_WIDTH'(1);
        end
      end

      default: begin
        stateD = StReleased;
        cntD   = '0;
      end
    endcase
  end

  assign ButtonLevel  = levelQ;
  assign PressPulse   = pressQ;
  assign ReleasePulse = releaseQ;

endmodule
